// File: rtl/wishbone_ram_slave_pkg.sv
// Shared Wishbone RAM slave definitions: bus widths and FSM state encoding.
package wishbone_ram_slave_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wishbone_ram_array.sv
// Single-port synchronous RAM, 2^ADDR_WIDTH x 32, with per-byte write enables.
// The read register only updates on a read access, so it holds the last read word.
module wishbone_ram_array
    import wishbone_ram_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [WB_SEL_W-1:0]   be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WB_DATA_W-1:0]  wdata,
    output logic [WB_DATA_W-1:0]  rdata
);

    logic [WB_DATA_W-1:0] mem [2**ADDR_WIDTH];

    // Byte-masked write or full-word registered read, one access per enabled edge
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < WB_SEL_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wishbone_ram_slave.sv
// Wishbone classic slave in front of a synchronous RAM with programmable wait states.
module wishbone_ram_slave
    import wishbone_ram_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wishbone_cyc_i,
    input  logic                 wishbone_stb_i,
    input  logic                 wishbone_we_i,
    input  logic [31:0]          wishbone_addr_i,
    input  logic [WB_SEL_W-1:0]  wishbone_sel_i,
    input  logic [WB_DATA_W-1:0] wishbone_data_i,
    output logic [WB_DATA_W-1:0] wishbone_data_o,
    output logic                 wishbone_ack_o
);

    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [31:0] WIN_MASK  = ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);

    wb_state_t state, state_next;
    logic [3:0] cnt, cnt_next;

    logic [31:0]          req_addr;
    logic [WB_DATA_W-1:0] req_data;
    logic                 req_we;
    logic [WB_SEL_W-1:0]  req_sel;

    logic                 ack_q;
    logic                 zero_q;
    logic                 latch;
    logic                 access;
    logic                 req;

    logic [31:0]          cur_addr;
    logic [WB_DATA_W-1:0] cur_data;
    logic                 cur_we;
    logic [WB_SEL_W-1:0]  cur_sel;
    logic                 in_window;
    logic [WB_DATA_W-1:0] ram_rdata;

    assign req = wishbone_cyc_i & wishbone_stb_i;

    // With zero wait states the access happens on the sampling edge, so the live
    // bus values feed the RAM; otherwise the latched request does.
    assign cur_addr = (state == IDLE) ? wishbone_addr_i : req_addr;
    assign cur_data = (state == IDLE) ? wishbone_data_i : req_data;
    assign cur_we   = (state == IDLE) ? wishbone_we_i   : req_we;
    assign cur_sel  = (state == IDLE) ? wishbone_sel_i  : req_sel;

    assign in_window = ((cur_addr ^ BASE_ADDR) & WIN_MASK) == '0;

    // Next-state, counter and access decision
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch      = 1'b0;
        access     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access     = 1'b1;
                        state_next = ACK;
                        cnt_next   = '0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == 4'd1) begin
                    access     = 1'b1;
                    state_next = ACK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter, request latch, ack and read-source flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            req_addr <= '0;
            req_data <= '0;
            req_we   <= 1'b0;
            req_sel  <= '0;
            ack_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ack_q <= (state_next == ACK);
            if (latch) begin
                req_addr <= wishbone_addr_i;
                req_data <= wishbone_data_i;
                req_we   <= wishbone_we_i;
                req_sel  <= wishbone_sel_i;
            end
            if (access && !cur_we) begin
                zero_q <= !in_window;
            end
        end
    end

    // The RAM read register is the data holding register; zero_q forces 0 after
    // reset and after out-of-window reads, so data_o changes only on completed reads.
    wishbone_ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (access && in_window && !rst),
        .we   (cur_we),
        .be   (cur_sel),
        .addr (cur_addr[ADDR_WIDTH+1:2]),
        .wdata(cur_data),
        .rdata(ram_rdata)
    );

    assign wishbone_data_o = zero_q ? '0 : ram_rdata;
    assign wishbone_ack_o  = ack_q;

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Self-checking bench for wishbone_ram_slave against a word-array reference model.
module tb_wishbone_ram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, cyc0 = 1'b0, stb0 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata, rdata0;
    logic        ack, ack0;

    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int exp_acks = 0;

    logic [31:0] model [int];

    always #5 clk = ~clk;

    wishbone_ram_slave #(.ADDR_WIDTH(12), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .wishbone_cyc_i(cyc), .wishbone_stb_i(stb), .wishbone_we_i(we),
        .wishbone_addr_i(addr), .wishbone_sel_i(sel), .wishbone_data_i(wdata),
        .wishbone_data_o(rdata), .wishbone_ack_o(ack)
    );

    wishbone_ram_slave #(.ADDR_WIDTH(12), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst(rst),
        .wishbone_cyc_i(cyc0), .wishbone_stb_i(stb0), .wishbone_we_i(we),
        .wishbone_addr_i(addr), .wishbone_sel_i(sel), .wishbone_data_i(wdata),
        .wishbone_data_o(rdata0), .wishbone_ack_o(ack0)
    );

    // Count every ack pulse of the main slave
    always @(negedge clk) if (ack) ack_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return a < 32'h0000_4000;
    endfunction

    // Reference model update: byte lanes of the word at a/4
    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!in_win(a)) return;
        w = model.exists(int'(a[13:2])) ? model[int'(a[13:2])] : 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        model[int'(a[13:2])] = w;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!in_win(a)) return 32'h0;
        return model[int'(a[13:2])];
    endfunction

    // One complete transfer; bus inputs other than cyc/stb are scrambled after sampling
    task automatic xfer(input bit which, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat);
        int n;
        bit got;
        @(negedge clk);
        we = w; addr = a; wdata = d; sel = s;
        if (which) begin cyc0 = 1'b1; stb0 = 1'b1; end
        else begin cyc = 1'b1; stb = 1'b1; end
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (which ? ack0 : ack) got = 1'b1;
            else begin
                we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom; sel = 4'($urandom);
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        rd = which ? rdata0 : rdata;
        lat = n - 1;
        if (!which && got) exp_acks++;
        cyc = 1'b0; stb = 1'b0; cyc0 = 1'b0; stb0 = 1'b0;
        @(posedge clk);
        #1;
        check("ack_width", 32'(which ? ack0 : ack), 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        int lat;
        xfer(1'b0, 1'b1, a, d, s, rd, lat);
        check("wr_lat", 32'(lat), 32'd2);
        model_write(a, d, s);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a);
        logic [31:0] rd;
        int lat;
        xfer(1'b0, 1'b0, a, $urandom, 4'($urandom), rd, lat);
        check("rd_lat", 32'(lat), 32'd2);
        check(tag, rd, model_read(a));
    endtask

    initial begin
        logic [31:0] rd, prior, a, d;
        logic [3:0]  s;
        int lat;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", rdata, 32'h0);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_data0", rdata0, 32'h0);
        @(negedge clk) rst = 1'b0;

        // Byte-masked write
        wr(32'h10, 32'hAABBCCDD, 4'b1111);
        wr(32'h10, 32'h11223344, 4'b0101);
        rd_chk("masked_rd", 32'h10);
        check("masked_const", rdata, 32'hAA22CC44);

        // Zero wait states on the second slave
        xfer(1'b1, 1'b1, 32'h4, 32'hCAFEF00D, 4'b1111, rd, lat);
        check("w0_wr_lat", 32'(lat), 32'd0);
        xfer(1'b1, 1'b0, 32'h4, 32'h0, 4'b0000, rd, lat);
        check("w0_rd_lat", 32'(lat), 32'd0);
        check("w0_rd_data", rd, 32'hCAFEF00D);

        // Abort during WAIT: stb dropped after one wait cycle
        wr(32'h20, 32'h01020304, 4'b1111);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'hDEADBEEF; sel = 4'b1111; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk) stb = 1'b0;
        @(negedge clk) cyc = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_ack", 32'(ack_cnt), 32'(exp_acks));
        check("abort_data", rdata, 32'hAA22CC44);
        rd_chk("abort_rd", 32'h20);

        // cyc without stb must not start a transfer
        @(negedge clk) cyc = 1'b1;
        repeat (5) @(negedge clk);
        cyc = 1'b0;
        check("cyc_only", 32'(ack_cnt), 32'(exp_acks));

        // Out-of-window access; word 0 aliases the low bits
        wr(32'h0, 32'h5A5A5A5A, 4'b1111);
        wr(32'h8000_0000, 32'h12345678, 4'b1111);
        rd_chk("oow_rd", 32'h8000_0000);
        check("oow_const", rdata, 32'h0);
        rd_chk("oow_alias", 32'h0);

        // Reset during WAIT of a write to 0x30
        wr(32'h30, 32'h33333333, 4'b1111);
        rd_chk("pre_rst_rd", 32'h30);
        @(negedge clk);
        we = 1'b1; addr = 32'h30; wdata = 32'hFFFF0000; sel = 4'b1111; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data", rdata, 32'h0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        cyc = 1'b0; stb = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_rst_ack", 32'(ack_cnt), 32'(exp_acks));
        check("post_rst_data", rdata, 32'h0);
        rd_chk("rst_word", 32'h30);

        // Back-to-back: 16 writes then 16 reads
        for (int i = 0; i < 16; i++) wr(32'h100 + 32'(4 * i), $urandom, 4'b1111);
        for (int i = 0; i < 16; i++) rd_chk("b2b_rd", 32'h100 + 32'(4 * i));
        check("b2b_acks", 32'(ack_cnt), 32'(exp_acks));

        // Randomized mixed traffic over a small pool, some out of window
        for (int i = 0; i < 40; i++) begin
            a = 32'h100 + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a = a | 32'h4000_0000;
            d = $urandom;
            s = 4'($urandom);
            if ($urandom_range(0, 1) == 1) wr(a, d, s);
            else rd_chk("rand_rd", a);
        end
        prior = rdata;
        repeat (3) @(negedge clk);
        check("hold_data", rdata, prior);
        check("final_acks", 32'(ack_cnt), 32'(exp_acks));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/wishbone_ram_slave.md
WISHBONE_RAM_SLAVE -- requirements
Module: wishbone_ram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: word-address bits; storage depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before ack; legal range 0..15.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte base address of the decoded window, aligned to 2^(ADDR_WIDTH+2).
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port wishbone_cyc_i  input  1  bus cycle active.
REQ-007 Port wishbone_stb_i  input  1  strobe; valid transfer request when high together with cyc.
REQ-008 Port wishbone_we_i  input  1  1 = write, 0 = read.
REQ-009 Port wishbone_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-010 Port wishbone_sel_i  input  4  byte-lane enables; bit n covers data bits [8n+7:8n].
REQ-011 Port wishbone_data_i  input  32  write data.
REQ-012 Port wishbone_data_o  output  32  registered read data.
REQ-013 Port wishbone_ack_o  output  1  registered transfer-complete pulse.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, ACK.
REQ-015 In IDLE, a rising edge that samples cyc_i=1 and stb_i=1 SHALL latch addr, data, we and sel. The FSM SHALL go to WAIT with counter=WAIT_CYCLES, or directly to ACK when WAIT_CYCLES=0.
REQ-016 In WAIT, if cyc_i=0 or stb_i=0 at an edge, the FSM SHALL abort to IDLE: no write, no ack, data_o unchanged.
REQ-017 In WAIT with counter=1, the next edge SHALL perform the access and enter ACK. Otherwise the counter SHALL decrement.
REQ-018 Latency: with the request sampled at edge T0, ack_o SHALL rise at edge T0+WAIT_CYCLES and stay high for exactly one cycle.
REQ-019 In ACK, the next edge SHALL return to IDLE unconditionally. A new request is accepted no earlier than the edge after that.
REQ-020 Write access: only the byte lanes with latched sel=1 SHALL be updated. Other lanes SHALL be preserved.
REQ-021 Read access: data_o SHALL load the full addressed word, independent of sel, at the edge entering ACK.
REQ-022 data_o SHALL hold its value until the next completed read. Writes and aborts SHALL not change it.
REQ-023 Word index = addr[ADDR_WIDTH+1:2].
REQ-024 Out of window: when addr[31:ADDR_WIDTH+2] differs from BASE_ADDR[31:ADDR_WIDTH+2]:
- reads SHALL return 32'h0;
- writes SHALL be dropped;
- ack SHALL still be generated with normal latency.
REQ-025 Input changes during WAIT or ACK (other than the abort condition) SHALL be ignored; the latched values govern.
REQ-026 cyc_i=1 with stb_i=0 in IDLE SHALL not start a transfer.

Reset
REQ-027 On rst=1, asynchronously:
- state = IDLE;
- counter = 0;
- wishbone_ack_o = 0;
- wishbone_data_o = 32'h0;
- latched request registers = 0.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no write and no ack. No ack SHALL appear after reset deasserts.
REQ-029 Memory contents SHALL NOT be reset.

Structure
REQ-030 FSM state encodings and the Wishbone data width (32) / select width (4) constants SHALL live in the shared defines header.
REQ-031 Storage SHALL be one sub-module, wishbone_ram_array: synchronous, one port, 4 byte-write-enables, 2^ADDR_WIDTH x 32.
REQ-032 The FSM, counter, address decode and output registers SHALL reside in wishbone_ram_slave.

Verification
REQ-033 Byte-masked write, WAIT_CYCLES=2:
- stimulus: write 0xAABBCCDD to 0x10, sel=1111; then write 0x11223344 to 0x10, sel=0101; then read 0x10;
- required: each ack rises 2 edges after its sampling edge; read returns 0xAA22CC44.
REQ-034 WAIT_CYCLES=0, read from 0x4:
- required: ack high in the cycle immediately after the sampling edge;
- required: ack is exactly one cycle wide.
REQ-035 Abort during WAIT:
- stimulus: write 0xDEADBEEF to 0x20; drop stb after 1 wait cycle;
- required: no ack; a subsequent read of 0x20 returns the prior value.
REQ-036 Out-of-window access:
- stimulus: write 0x12345678 to 0x8000_0000, then read it back;
- required: ack for both; read data = 0x0; no in-window word modified.
REQ-037 Reset during WAIT:
- stimulus: rst pulsed during WAIT of a write to 0x30;
- required: ack stays 0; data_o = 0; word 0x30 unchanged.
REQ-038 Back-to-back traffic:
- stimulus: 16 back-to-back writes then reads, driven by a master that drops stb after ack;
- required: all data match; one ack per transfer; no ack while in IDLE.
